// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences instruction fetch (IF) and data (MEM) requests
// onto one single-outstanding memory bus. FSM: IDLE -> ISSUE -> WAIT -> RESP.
// MEM has priority over IF, since it belongs to the older instruction.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN. When it is defined, a
// saturating streak counter forces an IF grant after MAX_MEM_STREAK
// consecutive MEM grants made while IF was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_rwtype,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  // backing memory bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [2:0]        bus_rwtype,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  // Fetches are always full-word reads.
  localparam logic [2:0] RWTYPE_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic owner_mem;    // 1 = current transaction belongs to MEM, 0 = IF
  logic discard;      // IF transaction flushed; suppress its completion
  logic if_done_q;
  logic if_elig;
  logic grant_mem;
  logic grant_if;
  logic force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_MEM_STREAK);

  logic [CNT_W-1:0] streak;

  assign force_if = if_elig && (streak == STREAK_MAX);

  // Count MEM grants that overtook a waiting, unflushed fetch; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (state == S_IDLE) begin
      if (grant_if || !if_req)
        streak <= '0;
      else if (grant_mem && if_elig && streak != STREAK_MAX)
        streak <= streak + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Arbitration: a flushed fetch is ineligible; MEM wins unless IF is forced.
  always_comb begin
    if_elig   = if_req & ~if_flush;
    grant_mem = mem_req & ~force_if;
    grant_if  = if_elig & ~grant_mem;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; bus handshakes are only honoured in their own state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_mem || grant_if) state_nxt = S_ISSUE;
      S_ISSUE: if (bus_ready)             state_nxt = S_WAIT;
      S_WAIT:  if (bus_rvalid)            state_nxt = S_RESP;
      S_RESP:                             state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner's fields into the bus registers and track ownership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_mem  <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_rwtype <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_mem || grant_if) begin
            owner_mem  <= grant_mem;
            bus_req    <= 1'b1;
            bus_we     <= grant_mem ? mem_we     : 1'b0;
            bus_rwtype <= grant_mem ? mem_rwtype : RWTYPE_WORD;
            bus_addr   <= grant_mem ? mem_addr   : if_addr;
            bus_wdata  <= grant_mem ? mem_wdata  : '0;
          end
        end
        S_ISSUE: if (bus_ready) bus_req <= 1'b0;
        default: ;
      endcase
    end
  end

  // Flush of an IF-owned transaction marks it discarded until back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      discard <= 1'b0;
    else if (state == S_RESP)
      discard <= 1'b0;
    else if (state != S_IDLE && !owner_mem && if_flush)
      discard <= 1'b1;
  end

  // Capture read data and raise the owner's one-cycle done for RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done_q <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_done_q <= 1'b0;
      mem_done  <= 1'b0;
      if (state == S_WAIT && bus_rvalid) begin
        if (owner_mem) begin
          mem_done  <= 1'b1;
          mem_rdata <= bus_rdata;
        end else if (!discard && !if_flush) begin
          if_done_q <= 1'b1;
          if_rdata  <= bus_rdata;
        end
      end
    end
  end

  // A flush arriving during RESP still kills the fetch completion.
  assign if_done = if_done_q & ~if_flush;
  assign busy    = (state != S_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for the single unified memory port shared by instruction fetch and the MEM stage. It takes word fetches from IF and load/store requests from MEM, grants one at a time, and drives a single-outstanding request/response bus. It returns read data and one-cycle completion pulses that the pipeline uses as stall release. It sits between the pipeline's memory users and the backing memory controller, and replaces direct wiring of the MEM stage to memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_MEM_STREAK, 4, consecutive MEM grants allowed while IF waits (starvation guard only)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_done or if_flush
- if_addr  in  ADDR_W  fetch address (word read, RWType fixed to word)
- if_flush  in  1  taken-branch/jump redirect; cancels the pending or in-flight fetch
- if_done  out  1  one-cycle pulse, fetch data valid
- if_rdata  out  DATA_W  fetch data, valid while if_done
- mem_req  in  1  data request; held with its fields until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_rwtype  in  3  access size/sign, passed through unchanged
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_done  out  1  one-cycle completion pulse (loads and stores)
- mem_rdata  out  DATA_W  load data, valid while mem_done
- bus_req  out  1  request to the backing memory
- bus_we, bus_rwtype, bus_addr, bus_wdata  out  1/3/ADDR_W/DATA_W  request fields, stable while bus_req is high
- bus_ready  in  1  request accepted this cycle
- bus_rvalid  in  1  completion, including write acknowledge
- bus_rdata  in  DATA_W  read data with bus_rvalid
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: arbitrate, latch the winner's fields and owner, then go to ISSUE. With no eligible request, stay in IDLE.
  - ISSUE: bus_req=1. On bus_ready, go to WAIT.
  - WAIT: on bus_rvalid, register bus_rdata and go to RESP.
  - RESP: pulse the owner's done (unless discarded), then go to IDLE.
- Priority: MEM over IF, because it is the older instruction.
- IF is ineligible in any IDLE cycle where if_flush=1.
- Bus outputs are registered from latched fields. Requester inputs are ignored outside IDLE.
- A flush while owner=IF in ISSUE/WAIT/RESP sets a discard flag. The bus transaction runs to completion and if_done is suppressed. The flag clears on return to IDLE.
- MEM transactions are never cancelled.
- bus_rvalid in IDLE/ISSUE is illegal and ignored. bus_ready outside ISSUE is ignored.
- Only one transaction is outstanding at a time.

## Timing
- Reset values: state IDLE, all outputs 0 (bus_req, bus_* fields, if_done, mem_done, rdata outputs, busy), streak counter 0, discard flag 0.
- Reset is asynchronous: asserting rst mid-transaction drops bus_req immediately and abandons the transaction. A later stray bus_rvalid is ignored.
- Cycle-level timing, with the request sampled in IDLE at cycle 0:
  - bus_req rises in cycle 1.
  - With zero-wait memory (bus_ready in cycle 1, bus_rvalid in cycle 2), done is high in cycle 3. Minimum latency is 3 cycles.
  - Back-to-back grants: the next arbitration happens in the IDLE cycle after RESP, giving a 4-cycle period per access.
- Simultaneous if_req and mem_req in IDLE: MEM wins, unless the starvation guard forces IF.
- Simultaneous if_flush and bus_rvalid in WAIT: discard applies.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A saturating counter (width ⌈log2(MAX_MEM_STREAK+1)⌉) increments on each MEM grant made while if_req=1 and not flushed.
  - It resets to 0 on an IF grant, or on an IDLE arbitration with if_req=0.
  - When it equals MAX_MEM_STREAK and IF is eligible, IF wins the next arbitration.
- Not defined: strict MEM priority and no counter logic. IF may wait indefinitely.

## Test plan
- Single load, mem_addr=0x100, zero-wait bus returning 0xDEADBEEF -> bus_req in cycle 1 with bus_addr=0x100 and bus_we=0; mem_done with mem_rdata=0xDEADBEEF in cycle 3; if_done stays 0.
- if_req (0x40) and mem_req (store 0x55 to 0x200) in the same cycle -> store is issued first with bus_wdata=0x55; fetch is issued in the IDLE cycle after mem_done; if_done follows 3 cycles later.
- Fetch in WAIT with bus_rvalid delayed 5 cycles, if_flush pulsed in cycle 2 -> bus transaction completes; if_done never asserts; busy falls after RESP.
- With MEM_ARB_STARVE_GUARD_EN and MAX_MEM_STREAK=4, mem_req and if_req held continuously -> grant order MEM,MEM,MEM,MEM,IF,MEM…; without the macro, MEM only.
- rst asserted in WAIT, then bus_rvalid pulsed after rst release -> bus_req=0 immediately; no done pulses; state IDLE; next mem_req is served normally.
- bus_ready held low for 3 cycles in ISSUE -> bus_req and bus_* fields stay stable and unchanged until acceptance.
